// File: rtl/xbus_link.sv
// Blocking rendezvous channel between two MC cores: writer and reader handshake through a clamped one-word buffer.
// Optional macro XBUS_DEADLOCK_EN builds the big-clock stall detector; otherwise deadlock is tied low.
module xbus_link #(
    parameter int DATA_W         = 11,
    parameter int VAL_MAX        = 999,
    parameter int CNT_W          = 16,
    parameter int DEADLOCK_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     posedge_big_clk,
    input  logic                     wr_req,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_ack,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     data_avail,
    output logic [CNT_W-1:0]         xfer_count,
    output logic                     deadlock
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PEND = 2'd1,
        RD_PEND = 2'd2
    } state_t;

    localparam logic signed [DATA_W-1:0] VAL_MAX_S = DATA_W'(VAL_MAX);
    localparam logic signed [DATA_W-1:0] VAL_MIN_S = DATA_W'(-VAL_MAX);

    function automatic logic signed [DATA_W-1:0] clamp_val(input logic signed [DATA_W-1:0] v);
        if (v > VAL_MAX_S) begin
            clamp_val = VAL_MAX_S;
        end else if (v < VAL_MIN_S) begin
            clamp_val = VAL_MIN_S;
        end else begin
            clamp_val = v;
        end
    endfunction

    state_t                     state_r;
    logic signed [DATA_W-1:0]   buf_r;
    logic                       wr_v_s;
    logic                       rd_v_s;
    logic                       xfer_s;
    logic signed [DATA_W-1:0]   clamp_s;
    logic signed [DATA_W-1:0]   xfer_val_s;

    // Request qualification (a request seen during its own ack is ignored) and transfer decode.
    always_comb begin
        wr_v_s     = wr_req & ~wr_ack;
        rd_v_s     = rd_req & ~rd_ack;
        clamp_s    = clamp_val(wr_data);
        xfer_s     = 1'b0;
        xfer_val_s = clamp_s;
        case (state_r)
            IDLE: begin
                xfer_s     = wr_v_s & rd_v_s;
                xfer_val_s = clamp_s;
            end
            WR_PEND: begin
                xfer_s     = rd_v_s;
                xfer_val_s = buf_r;
            end
            RD_PEND: begin
                xfer_s     = wr_v_s;
                xfer_val_s = clamp_s;
            end
            default: begin
                xfer_s     = 1'b0;
                xfer_val_s = clamp_s;
            end
        endcase
    end

    // Rendezvous FSM with registered handshake and data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            buf_r      <= {DATA_W{1'b0}};
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_data    <= {DATA_W{1'b0}};
            data_avail <= 1'b0;
            xfer_count <= {CNT_W{1'b0}};
        end else begin
            wr_ack <= xfer_s;
            rd_ack <= xfer_s;
            if (xfer_s) begin
                rd_data    <= xfer_val_s;
                xfer_count <= xfer_count + CNT_W'(1);
                state_r    <= IDLE;
                data_avail <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (wr_v_s) begin
                            // Writer arrived alone: capture now so later wr_data changes cannot leak through.
                            buf_r      <= clamp_s;
                            state_r    <= WR_PEND;
                            data_avail <= 1'b1;
                        end else if (rd_v_s) begin
                            state_r    <= RD_PEND;
                            data_avail <= 1'b0;
                        end else begin
                            state_r    <= IDLE;
                            data_avail <= 1'b0;
                        end
                    end
                    WR_PEND: begin
                        state_r    <= WR_PEND;
                        data_avail <= 1'b1;
                    end
                    RD_PEND: begin
                        state_r    <= RD_PEND;
                        data_avail <= 1'b0;
                    end
                    default: begin
                        state_r    <= IDLE;
                        data_avail <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef XBUS_DEADLOCK_EN
    localparam int FC_W = $clog2(DEADLOCK_LIMIT + 1);

    logic [FC_W-1:0] frame_cnt_r;

    // Count big-clock frames spent pending; latch a sticky flag once the limit is hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= {FC_W{1'b0}};
            deadlock    <= 1'b0;
        end else if (xfer_s || (state_r == IDLE)) begin
            frame_cnt_r <= {FC_W{1'b0}};
        end else if (posedge_big_clk && (frame_cnt_r != FC_W'(DEADLOCK_LIMIT))) begin
            frame_cnt_r <= frame_cnt_r + FC_W'(1);
            if ((frame_cnt_r + FC_W'(1)) == FC_W'(DEADLOCK_LIMIT)) begin
                deadlock <= 1'b1;
            end else begin
                deadlock <= deadlock;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end
`else
    logic unused_big_clk_s;

    assign unused_big_clk_s = posedge_big_clk ^ (DEADLOCK_LIMIT > 0);
    assign deadlock         = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_link.sv
// Directed bench for xbus_link: rendezvous ordering, clamping, back-to-back handshakes, reset drop and stall flag.
module tb_xbus_link;

    localparam int DATA_W = 11;
    localparam int CNT_W  = 16;
`ifdef XBUS_DEADLOCK_EN
    localparam bit DL_EN = 1'b1;
`else
    localparam bit DL_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     posedge_big_clk;
    logic                     wr_req;
    logic signed [DATA_W-1:0] wr_data;
    logic                     wr_ack;
    logic                     rd_req;
    logic                     rd_ack;
    logic signed [DATA_W-1:0] rd_data;
    logic                     data_avail;
    logic [CNT_W-1:0]         xfer_count;
    logic                     deadlock;

    int vectors = 0;
    int fails   = 0;

    xbus_link dut (
        .clk            (clk),
        .reset          (reset),
        .posedge_big_clk(posedge_big_clk),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .rd_req         (rd_req),
        .rd_ack         (rd_ack),
        .rd_data        (rd_data),
        .data_avail     (data_avail),
        .xfer_count     (xfer_count),
        .deadlock       (deadlock)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ack(input string tag, input logic exp);
        chk({tag, "_wr_ack"}, {31'd0, wr_ack}, {31'd0, exp});
        chk({tag, "_rd_ack"}, {31'd0, rd_ack}, {31'd0, exp});
    endtask

    task automatic idle_inputs();
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        posedge_big_clk = 1'b0;
        wr_req          = 1'b0;
        rd_req          = 1'b0;
        wr_data         = 11'sd0;
        step();
        step();
        reset = 1'b0;
        chk_ack("rst", 1'b0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_avail", {31'd0, data_avail}, 0);
        chk("rst_count", {16'd0, xfer_count}, 0);
        chk("rst_deadlock", {31'd0, deadlock}, 0);

        // Writer first: data captured at cycle 0, reader arrives at cycle 5
        wr_req  = 1'b1;
        wr_data = 11'sd42;
        for (int c = 1; c <= 5; c++) begin
            step();
            wr_data = 11'sd100;
            chk("wf_avail", {31'd0, data_avail}, 1);
            chk_ack("wf_wait", 1'b0);
        end
        rd_req = 1'b1;
        step();
        chk_ack("wf_xfer", 1'b1);
        chk("wf_rd_data", rd_data, 42);
        chk("wf_avail_drop", {31'd0, data_avail}, 0);
        chk("wf_count", {16'd0, xfer_count}, 1);
        idle_inputs();
        step();
        chk_ack("wf_after", 1'b0);
        chk("wf_hold", rd_data, 42);

        // Reader first, positive clamp
        rd_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk_ack("rf_wait", 1'b0);
            chk("rf_avail", {31'd0, data_avail}, 0);
        end
        wr_req  = 1'b1;
        wr_data = 11'sd1023;
        step();
        chk_ack("rf_xfer", 1'b1);
        chk("rf_clamp_pos", rd_data, 999);
        chk("rf_count", {16'd0, xfer_count}, 2);
        idle_inputs();
        step();

        // Reader first, negative clamp
        rd_req = 1'b1;
        step();
        step();
        chk_ack("rfn_wait", 1'b0);
        wr_req  = 1'b1;
        wr_data = -11'sd1024;
        step();
        chk_ack("rfn_xfer", 1'b1);
        chk("rfn_clamp_neg", rd_data, -999);
        chk("rfn_count", {16'd0, xfer_count}, 3);
        idle_inputs();
        step();

        // Simultaneous requests
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = -11'sd7;
        step();
        chk_ack("sim_xfer", 1'b1);
        chk("sim_rd_data", rd_data, -7);
        chk("sim_avail", {31'd0, data_avail}, 0);
        chk("sim_count", {16'd0, xfer_count}, 4);
        idle_inputs();
        step();
        chk("sim_avail2", {31'd0, data_avail}, 0);

        // Held requests: one transfer every two cycles
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 11'sd1;
        step();
        chk_ack("held1", 1'b1);
        chk("held1_data", rd_data, 1);
        chk("held1_count", {16'd0, xfer_count}, 5);
        wr_data = 11'sd2;
        step();
        chk_ack("held_gap1", 1'b0);
        chk("held_gap1_avail", {31'd0, data_avail}, 0);
        step();
        chk_ack("held2", 1'b1);
        chk("held2_data", rd_data, 2);
        chk("held2_count", {16'd0, xfer_count}, 6);
        wr_data = 11'sd3;
        step();
        chk_ack("held_gap2", 1'b0);
        step();
        chk_ack("held3", 1'b1);
        chk("held3_data", rd_data, 3);
        chk("held3_count", {16'd0, xfer_count}, 7);
        idle_inputs();
        step();

        // Boundary: exact limits pass unchanged
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 11'sd999;
        step();
        chk("edge_pos", rd_data, 999);
        idle_inputs();
        step();
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = -11'sd999;
        step();
        chk("edge_neg", rd_data, -999);
        chk("edge_count", {16'd0, xfer_count}, 9);
        idle_inputs();
        step();

        // Reset while the writer is pending drops the buffered value
        wr_req  = 1'b1;
        wr_data = 11'sd5;
        step();
        chk("rm_avail", {31'd0, data_avail}, 1);
        step();
        reset  = 1'b1;
        wr_req = 1'b0;
        step();
        reset = 1'b0;
        chk_ack("rm_reset", 1'b0);
        chk("rm_rd_data", rd_data, 0);
        chk("rm_avail0", {31'd0, data_avail}, 0);
        chk("rm_count", {16'd0, xfer_count}, 0);
        rd_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_ack("rm_no_ack", 1'b0);
            chk("rm_no_data", rd_data, 0);
        end
        wr_req  = 1'b1;
        wr_data = -11'sd1000;
        step();
        chk_ack("rm_late", 1'b1);
        chk("rm_late_data", rd_data, -999);
        chk("rm_late_count", {16'd0, xfer_count}, 1);
        idle_inputs();
        step();

        // Frame pulse coincident with a transfer does not delay it
        wr_req          = 1'b1;
        rd_req          = 1'b1;
        wr_data         = 11'sd300;
        posedge_big_clk = 1'b1;
        step();
        posedge_big_clk = 1'b0;
        chk_ack("bc_xfer", 1'b1);
        chk("bc_data", rd_data, 300);
        chk("bc_count", {16'd0, xfer_count}, 2);
        chk("bc_deadlock", {31'd0, deadlock}, 0);
        idle_inputs();
        step();

        // Stalled reader across four frames
        rd_req = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            posedge_big_clk = 1'b1;
            step();
            posedge_big_clk = 1'b0;
            step();
            chk("dl_flag", {31'd0, deadlock}, {31'd0, (DL_EN && (i == 3))});
            chk_ack("dl_wait", 1'b0);
        end
        wr_req  = 1'b1;
        wr_data = 11'sd8;
        step();
        chk_ack("dl_xfer", 1'b1);
        chk("dl_data", rd_data, 8);
        chk("dl_count", {16'd0, xfer_count}, 3);
        chk("dl_sticky", {31'd0, deadlock}, {31'd0, DL_EN});
        idle_inputs();
        step();
        step();
        chk("dl_sticky2", {31'd0, deadlock}, {31'd0, DL_EN});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
